// File: rtl/apu_dispatch_queue.sv
// In-order APU request queue: buffers core requests, issues them to the vector
// back-end under an outstanding-instruction limit, and formats returning results.
module apu_dispatch_queue #(
  parameter int DEPTH     = 4,
  parameter int VLEN      = 128,
  parameter int OP_W      = 6,
  parameter int FLAGS_W   = 15,
  parameter int MAX_OUTST = 4
) (
  input  logic                          clk,
  input  logic                          n_reset,
  input  logic                          apu_req,
  output logic                          apu_gnt,
  input  logic [2:0][31:0]              apu_operands_i,
  input  logic [OP_W-1:0]               apu_op,
  input  logic [FLAGS_W-1:0]            apu_flags_i,
  output logic                          apu_rvalid,
  output logic [31:0]                   apu_result,
  output logic                          core_halt_o,
  input  logic                          flush_i,
  output logic                          iss_valid_o,
  input  logic                          iss_ready_i,
  output logic [2:0][31:0]              iss_operands_o,
  output logic [OP_W-1:0]               iss_op_o,
  output logic [FLAGS_W-1:0]            iss_flags_o,
  input  logic                          res_valid_i,
  input  logic [1:0]                    res_select_i,
  input  logic [7:0]                    res_vl_i,
  input  logic [VLEN-1:0]               res_vs2_i,
  input  logic [1:0]                    res_vsew_i,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTST + 1);

  typedef struct packed {
    logic [2:0][31:0]     operands;
    logic [OP_W-1:0]      op;
    logic [FLAGS_W-1:0]   flags;
  } entry_t;

  // Scalar result: VL readback or element 0 of vs2 sign-extended per SEW.
  function automatic logic [31:0] fmt_result(input logic [1:0]  sel,
                                             input logic [7:0]  vl,
                                             input logic [31:0] elem0,
                                             input logic [1:0]  vsew);
    logic [31:0] r;
    r = 32'd0;
    case (sel)
      2'd0: r = {24'd0, vl};
      2'd1: begin
        case (vsew)
          2'd0:    r = {{24{elem0[7]}}, elem0[7:0]};
          2'd1:    r = {{16{elem0[15]}}, elem0[15:0]};
          2'd2:    r = elem0;
          default: r = 32'd0;
        endcase
      end
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic            halt_q, halt_d;
  logic            rvalid_q;
  logic [31:0]     result_q, result_d;
  logic            err_q, err_d;
  logic            full_s, empty_s, push_s, pop_s, res_dec_s, iss_valid_s;
  entry_t          wr_entry_s, head_s;

  generate
    if (VLEN > 32) begin : g_unused_vs2
      logic unused_vs2_s;
      assign unused_vs2_s = ^res_vs2_i[VLEN-1:32];
    end
  endgenerate

  assign full_s      = (count_q == CW'(DEPTH));
  assign empty_s     = (count_q == {CW{1'b0}});
  assign apu_gnt     = n_reset & ~full_s & ~flush_i;
  assign push_s      = apu_req & apu_gnt;
  assign iss_valid_s = ~empty_s & (outst_q < OW'(MAX_OUTST));
  assign pop_s       = iss_valid_s & iss_ready_i;
  // A completion with nothing in flight is a protocol error and must not underflow.
  assign res_dec_s   = res_valid_i & (outst_q != {OW{1'b0}});

  assign wr_entry_s  = '{operands: apu_operands_i, op: apu_op, flags: apu_flags_i};
  assign head_s      = mem_q[rd_ptr_q];

  assign iss_valid_o    = iss_valid_s;
  assign iss_operands_o = head_s.operands;
  assign iss_op_o       = head_s.op;
  assign iss_flags_o    = head_s.flags;
  assign count_o        = count_q;
  assign core_halt_o    = halt_q;
  assign apu_rvalid     = rvalid_q;
  assign apu_result     = result_q;
  assign err_o          = err_q;

  // Next-state for pointers, occupancy, outstanding count and result.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    outst_d  = outst_q;
    if (flush_i) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    case ({pop_s, res_dec_s})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase
    halt_d = (count_q >= CW'(DEPTH - 1));
    err_d  = err_q | (res_valid_i & ~res_dec_s);
    if (res_valid_i) begin
      result_d = fmt_result(res_select_i, res_vl_i, res_vs2_i[31:0], res_vsew_i);
    end else begin
      result_d = result_q;
    end
  end

  // State registers and FIFO storage.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      outst_q  <= {OW{1'b0}};
      halt_q   <= 1'b0;
      rvalid_q <= 1'b0;
      result_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= wr_entry_s;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      halt_q   <= halt_d;
      rvalid_q <= res_valid_i;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: doc/apu_dispatch_queue.md
Name: apu_dispatch_queue

Overview:
Parametrised APU front-end that sits between the core's APU request port and the vector decoder and pipeline. It buffers up to DEPTH accepted requests so the core is not stalled on every vector instruction, and issues them in order to the back-end with a valid/ready handshake. It collects back-end completions, formats the 32-bit scalar result (VL readback, or element 0 of vs2 sign-extended per SEW over a VLEN-wide register), and returns it with an apu_rvalid pulse. Unlike the single-outstanding front-end, it supports multiple outstanding instructions, tracks outstanding completions, and has a flush path.

Parameters:
DEPTH, 4, request FIFO entries (power of two, >=2)
VLEN, 128, vector register width in bits (>=32, multiple of 32)
OP_W, 6, apu_op width
FLAGS_W, 15, apu_flags_i width
MAX_OUTST, 4, max issued-but-not-completed instructions

Ports:
clk  in  1  clock
n_reset  in  1  asynchronous active-low reset
apu_req  in  1  core request valid
apu_gnt  out  1  request accepted this cycle
apu_operands_i  in  3x32  operands a/b/c
apu_op  in  OP_W  opcode
apu_flags_i  in  FLAGS_W  instruction flags
apu_rvalid  out  1  result valid pulse
apu_result  out  32  scalar result
core_halt_o  out  1  queue almost full
flush_i  in  1  synchronous queue flush
iss_valid_o  out  1  head entry valid to decoder
iss_ready_i  in  1  decoder accepts head
iss_operands_o  out  3x32  head operands
iss_op_o  out  OP_W  head opcode
iss_flags_o  out  FLAGS_W  head flags
res_valid_i  in  1  back-end completion
res_select_i  in  2  0=VL, 1=VS2_0, 2=NONE, 3=reserved
res_vl_i  in  8  updated VL
res_vs2_i  in  VLEN  vs2 register data
res_vsew_i  in  2  SEW: 0=8b, 1=16b, 2=32b
count_o  out  $clog2(DEPTH)+1  FIFO occupancy
err_o  out  1  sticky protocol error

Behaviour:
- Clock clk, reset n_reset asynchronous active-low. On reset: FIFO empty, pointers 0, count_o=0, outstanding=0, apu_gnt=0 while in reset, apu_rvalid=0, apu_result=0, iss_valid_o=0, core_halt_o=0, err_o=0.
- apu_gnt = !full (combinational). Push when apu_req && apu_gnt. No same-cycle bypass: a pushed entry appears at iss_* the next cycle at the earliest.
- iss_valid_o = !empty && (outstanding < MAX_OUTST). iss_* are driven from the head entry, and are stable while iss_valid_o && !iss_ready_i. Pop when iss_valid_o && iss_ready_i; outstanding increments on pop.
- Simultaneous push and pop: count unchanged; legal when full is false. When full, no push occurs, so a pop frees the slot only for the next cycle.
- Pointers wrap modulo DEPTH. full = (count==DEPTH), empty = (count==0).
- core_halt_o = (count >= DEPTH-1), registered, so it asserts the cycle after the threshold is reached.
- flush_i: next cycle, FIFO is empty and count=0. Outstanding is untouched, because in-flight results still return. Flush takes priority over a same-cycle push, which is dropped, and apu_gnt is forced low while flush_i is high. A pop in the same cycle as a flush completes normally.
- Result formatting, registered, 1-cycle latency: on res_valid_i, apu_rvalid=1 the next cycle for exactly one cycle. apu_result is set as follows:
  - sel=0: zero-extended res_vl_i.
  - sel=1, vsew=0: sign-extended res_vs2_i[7:0].
  - sel=1, vsew=1: sign-extended res_vs2_i[15:0].
  - sel=1, vsew=2: res_vs2_i[31:0].
  - sel=1, vsew=3: 0.
  - sel=2 or 3: 0.
  - apu_result holds its value until the next rvalid.
- Outstanding decrements on res_valid_i. A same-cycle pop and res_valid leaves it unchanged. A res_valid_i with outstanding==0 still produces the rvalid pulse, does not decrement, and sets err_o. err_o clears only on reset.
- Reset mid-operation discards all entries and outstanding state immediately.

Test Plan:
- Push 4 requests back-to-back with iss_ready_i=0, DEPTH=4 -> apu_gnt low on the 5th cycle; count_o=4; core_halt_o high from the cycle after count reaches 3.
- iss_ready_i=1 with continuous apu_req -> one push and one pop per cycle; count stays at 1; issue order matches push order (op 0x01,0x02,0x03...).
- res_valid_i with sel=1, vsew=0, res_vs2_i[7:0]=0x80 -> next cycle apu_rvalid=1, apu_result=0xFFFFFF80. With vsew=1 and [15:0]=0x7FFF -> 0x00007FFF.
- res_valid_i with sel=0, res_vl_i=16 -> apu_result=0x00000010, one-cycle rvalid pulse.
- MAX_OUTST=2: pop 2 entries with no results -> iss_valid_o drops with entries still queued; one res_valid_i -> iss_valid_o reasserts the next cycle.
- 3 entries queued, then flush_i and apu_req in the same cycle -> count_o=0 the next cycle and the request is not granted. res_valid_i with outstanding=0 -> err_o=1 and stays set until n_reset.
